// File: rtl/axi4lite_pkg.sv
// Shared types and constants for the 2-bit-address, 8-bit-data AXI4-Lite register slave.
package axi4lite_pkg;

    localparam int AXI_ADDR_W = 2;
    localparam int AXI_DATA_W = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [AXI_ADDR_W-1:0] REG0 = 2'd0;
    localparam logic [AXI_ADDR_W-1:0] REG1 = 2'd1;
    localparam logic [AXI_ADDR_W-1:0] REG2 = 2'd2;
    localparam logic [AXI_ADDR_W-1:0] REG3 = 2'd3;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

endpackage

// File: rtl/axi4lite_reg_slave_if.sv
// AXI4-Lite bus bundle between the team master and the register slave.
interface axi4lite_reg_slave_if #(
    parameter int ADDR_WIDTH = axi4lite_pkg::AXI_ADDR_W,
    parameter int DATA_WIDTH = axi4lite_pkg::AXI_DATA_W
);
    logic [ADDR_WIDTH-1:0] s_awaddr;
    logic                  s_awvalid;
    logic                  s_awready;
    logic [DATA_WIDTH-1:0] s_wdata;
    logic                  s_wvalid;
    logic                  s_wready;
    logic [1:0]            s_bresp;
    logic                  s_bvalid;
    logic                  s_bready;
    logic [ADDR_WIDTH-1:0] s_araddr;
    logic                  s_arvalid;
    logic                  s_arready;
    logic [DATA_WIDTH-1:0] s_rdata;
    logic [1:0]            s_rresp;
    logic                  s_rvalid;
    logic                  s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output s_arready, s_rdata, s_rresp, s_rvalid
    );

endinterface

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite responder: three R/W byte registers plus a read-only status byte at address 3.
// Independent write and read FSMs; every ready/valid output comes straight from flops.
module axi4lite_reg_slave
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH = AXI_ADDR_W,
    parameter int DATA_WIDTH = AXI_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    axi4lite_reg_slave_if.slave   bus,
    input  logic [DATA_WIDTH-1:0] status_in,
    output logic [DATA_WIDTH-1:0] reg0_out,
    output logic [DATA_WIDTH-1:0] reg1_out,
    output logic [DATA_WIDTH-1:0] reg2_out
);

    w_state_e              w_state_q, w_state_d;
    r_state_e              r_state_q, r_state_d;
    logic                  ready_en_q, ready_en_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] reg0_q, reg0_d;
    logic [DATA_WIDTH-1:0] reg1_q, reg1_d;
    logic [DATA_WIDTH-1:0] reg2_q, reg2_d;

    logic                  aw_rdy, w_rdy, ar_rdy;
    logic                  aw_hs, w_hs, ar_hs;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_sel;

    // ready_en_q keeps all readies low for the cycle following a reset edge.
    assign aw_rdy = ready_en_q && (w_state_q == W_IDLE) && !aw_held_q;
    assign w_rdy  = ready_en_q && (w_state_q == W_IDLE) && !w_held_q;
    assign ar_rdy = ready_en_q && (r_state_q == R_IDLE);

    assign aw_hs = bus.s_awvalid && aw_rdy;
    assign w_hs  = bus.s_wvalid && w_rdy;
    assign ar_hs = bus.s_arvalid && ar_rdy;

    assign wr_addr = aw_held_q ? awaddr_q : bus.s_awaddr;
    assign wr_data = w_held_q ? wdata_q : bus.s_wdata;

    assign bus.s_awready = aw_rdy;
    assign bus.s_wready  = w_rdy;
    assign bus.s_arready = ar_rdy;
    assign bus.s_bvalid  = (w_state_q == W_RESP);
    assign bus.s_bresp   = bresp_q;
    assign bus.s_rvalid  = (r_state_q == R_DATA);
    assign bus.s_rdata   = rdata_q;
    assign bus.s_rresp   = RESP_OKAY;

    assign reg0_out = reg0_q;
    assign reg1_out = reg1_q;
    assign reg2_out = reg2_q;

    always_comb begin
        rd_sel = status_in;
        case (bus.s_araddr)
            REG0:    rd_sel = reg0_q;
            REG1:    rd_sel = reg1_q;
            REG2:    rd_sel = reg2_q;
            default: rd_sel = status_in;
        endcase
    end

    always_comb begin
        ready_en_d = 1'b1;
        w_state_d  = w_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        bresp_d    = bresp_q;
        reg0_d     = reg0_q;
        reg1_d     = reg1_q;
        reg2_d     = reg2_q;

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = bus.s_awaddr;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = bus.s_wdata;
                end
                if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                    w_state_d = W_RESP;
                    bresp_d   = RESP_OKAY;
                    case (wr_addr)
                        REG0:    reg0_d = wr_data;
                        REG1:    reg1_d = wr_data;
                        REG2:    reg2_d = wr_data;
                        default: bresp_d = RESP_SLVERR;
                    endcase
                end
            end
            W_RESP: begin
                if (bus.s_bready) begin
                    w_state_d = W_IDLE;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read data is taken from the pre-edge register values, so a same-edge write is not seen.
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    rdata_d   = rd_sel;
                end
            end
            R_DATA: begin
                if (bus.s_rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en_q <= 1'b0;
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            bresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            reg0_q     <= '0;
            reg1_q     <= '0;
            reg2_q     <= '0;
        end else begin
            ready_en_q <= ready_en_d;
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            bresp_q    <= bresp_d;
            rdata_q    <= rdata_d;
            reg0_q     <= reg0_d;
            reg1_q     <= reg1_d;
            reg2_q     <= reg2_d;
        end
    end

endmodule

// File: doc/axi4lite_reg_slave.md
# axi4lite_reg_slave

AXI4-Lite responder that terminates the 2-bit-address, 8-bit-data bus driven by the team's AXI4-Lite master. It holds three read/write 8-bit registers and one read-only status register, and answers every transaction with a proper B or R response. It sits below the master inside the top-level wrapper, and its register outputs drive user logic.

## Interface
- ADDR_WIDTH, 2, address bits (4 byte registers; fixed at 2)
- DATA_WIDTH, 8, data bits (fixed at 8)
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous and active-high
- s_awaddr  in  ADDR_WIDTH  write address
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_wdata  in  DATA_WIDTH  write data
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_bresp  out  2  write response: 00 OKAY, 10 SLVERR
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_araddr  in  ADDR_WIDTH  read address
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_rdata  out  DATA_WIDTH  read data
- s_rresp  out  2  read response (always 00)
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- status_in  in  DATA_WIDTH  value returned when reading address 3
- reg0_out, reg1_out, reg2_out  out  DATA_WIDTH each  current register contents

## Operation
- Register map:
  - Addresses 0–2: read/write, reset value 0x00.
  - Address 3: read-only, returns status_in.
  - A write to address 3 leaves all registers unchanged and returns SLVERR.
- Write FSM states:
  - W_IDLE: s_awready = ~aw_held, s_wready = ~w_held. Each channel latches independently on its handshake, in any order, including the same cycle.
  - When both channels are held (or complete in the same cycle), the write commits on that edge and the FSM moves to W_RESP.
  - W_RESP: s_bvalid = 1, s_awready = s_wready = 0. On s_bvalid & s_bready, clear both held flags and return to W_IDLE.
- Read FSM states:
  - R_IDLE: s_arready = 1. On handshake, s_rdata is registered from the addressed register (address 3 samples status_in) and the FSM moves to R_DATA.
  - R_DATA: s_rvalid = 1, s_arready = 0. s_rdata and s_rresp hold stable until s_rvalid & s_rready, then return to R_IDLE.
- The read and write FSMs are fully independent and may be active at the same time.
- Same-edge collision: if a write commit and an AR handshake hit the same address on the same edge, the read returns the pre-write value.
- Reset outputs:
  - s_awready, s_wready, s_arready = 0 in the reset cycle, then 1.
  - s_bvalid, s_rvalid = 0; s_bresp, s_rresp = 00; s_rdata = 0x00.
  - All registers = 0x00.
- Reset mid-transaction: held AW/W and pending B/R responses are discarded. A write that has not committed has no effect.

## Timing
- Write latency: s_bvalid rises the cycle after the edge on which the last of AW/W completes.
- Read latency: s_rvalid rises the cycle after the AR handshake.
- reg*_out updates on the commit edge and is visible in the same cycle that s_bvalid rises.
- Throughput: at most one write and one read outstanding. Back-to-back writes take at least 2 cycles each when s_bready is held high.
- No combinational path from any input to any ready or valid output.

## Structure
- Shared package axi4lite_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - Register address constants REG0..REG3.
  - Write-state and read-state enums.
- Single module. No sub-module is needed; the register file is inline.

## Test plan
- Reset, then AW+W in the same cycle: addr 1, data 0x04. Expect bvalid one cycle later with bresp 00 and reg1_out = 0x04. Read addr 1: expect rdata 0x04, rresp 00.
- W first (data 0xA5), AW (addr 2) three cycles later. Expect wready low after the W handshake, bvalid the cycle after the AW handshake, reg2_out = 0xA5.
- Write addr 3, data 0xFF. Expect bresp 10 and all registers unchanged. With status_in = 0x3C, read addr 3: expect rdata 0x3C.
- Hold bready and rready low for 5 cycles. Expect bvalid, rvalid, bresp and rdata stable, and awready, wready, arready low throughout.
- Concurrent write to addr 0 (0x11) and AR to addr 0 on the same edge. Expect the read to return 0x00; a following read returns 0x11.
- Assert rst while a B response is pending. Expect bvalid = 0 and all registers = 0x00 the next cycle, with the readies high one cycle later.
